// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write slave among NUM_MST masters, one whole
// AW/W/B transaction at a time; regenerates wid/wlast and flags master protocol errors.
module axi_wr_arbiter #(
   parameter int NUM_MST = 2,
   parameter int PTR_W   = $clog2(NUM_MST)
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [NUM_MST*45-1:0] s_awpayload,
   input  logic [NUM_MST-1:0]    s_awvalid,
   output logic [NUM_MST-1:0]    s_awready,
   input  logic [NUM_MST*41-1:0] s_wpayload,
   input  logic [NUM_MST-1:0]    s_wvalid,
   output logic [NUM_MST-1:0]    s_wready,
   output logic [3:0]            s_bid,
   output logic [1:0]            s_bresp,
   output logic [NUM_MST-1:0]    s_bvalid,
   input  logic [NUM_MST-1:0]    s_bready,
   output logic [44:0]           m_awpayload,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [40:0]           m_wpayload,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [3:0]            m_bid,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [NUM_MST-1:0]    grant,
   output logic [2:0]            err
);

   localparam int AW_W = 45;
   localparam int W_W  = 41;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   g_idx_q, g_idx_d;
   logic [NUM_MST-1:0] grant_q, grant_d;
   logic [3:0]         beat_cnt_q, beat_cnt_d;
   logic [3:0]         awid_q, awid_d;
   logic [3:0]         awlen_q, awlen_d;
   logic [2:0]         err_q, err_d;

   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [NUM_MST-1:0] win_oh;
   logic [AW_W-1:0]    aw_sel;
   logic [W_W-1:0]     w_sel;
   logic               wlast_gen;
   logic               aw_hs, w_hs, b_hs;

   // Round-robin search: first requester at or above ptr, otherwise the lowest one below it.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (!win_found && s_awvalid[i] && (i >= int'(ptr_q))) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(i);
            win_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_MST; i++) begin
         if (!win_found && s_awvalid[i]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(i);
            win_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      aw_sel = '0;
      w_sel  = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant_q[i]) begin
            aw_sel = s_awpayload[AW_W*i +: AW_W];
            w_sel  = s_wpayload[W_W*i +: W_W];
         end
      end
   end

   assign wlast_gen = (beat_cnt_q == awlen_q);
   assign aw_hs     = (|(s_awvalid & grant_q)) && m_awready;
   assign w_hs      = (|(s_wvalid & grant_q)) && m_wready;
   assign b_hs      = m_bvalid && (|(s_bready & grant_q));

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      g_idx_d     = g_idx_q;
      grant_d     = grant_q;
      beat_cnt_d  = beat_cnt_q;
      awid_d      = awid_q;
      awlen_d     = awlen_q;
      err_d       = err_q;
      s_awready   = '0;
      s_wready    = '0;
      s_bvalid    = '0;
      m_awvalid   = 1'b0;
      m_awpayload = '0;
      m_wvalid    = 1'b0;
      m_wpayload  = '0;
      m_bready    = 1'b0;
      s_bid       = m_bid;
      s_bresp     = m_bresp;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d = win_oh;
               g_idx_d = win_idx;
               state_d = ADDR;
            end
         end
         ADDR: begin
            m_awvalid   = |(s_awvalid & grant_q);
            m_awpayload = aw_sel;
            s_awready   = grant_q & {NUM_MST{m_awready}};
            if (aw_hs) begin
               awid_d     = aw_sel[44:41];
               awlen_d    = aw_sel[8:5];
               beat_cnt_d = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            m_wvalid   = |(s_wvalid & grant_q);
            m_wpayload = {awid_q, w_sel[36:1], wlast_gen};
            s_wready   = grant_q & {NUM_MST{m_wready}};
            if (w_hs) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
               if (w_sel[0] != wlast_gen)     err_d[0] = 1'b1;
               if (w_sel[40:37] != awid_q)    err_d[1] = 1'b1;
               // Burst length comes from awlen alone; the master's wlast is only audited.
               if (wlast_gen)                 state_d  = RESP;
            end
         end
         RESP: begin
            m_bready = |(s_bready & grant_q);
            s_bvalid = grant_q & {NUM_MST{m_bvalid}};
            if (b_hs) begin
               if (m_bid != awid_q) err_d[2] = 1'b1;
               ptr_d   = (g_idx_q == PTR_W'(NUM_MST - 1)) ? '0 : g_idx_q + 1'b1;
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values together.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         g_idx_q    <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         awid_q     <= '0;
         awlen_q    <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         g_idx_q    <= g_idx_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         awid_q     <= awid_d;
         awlen_q    <= awlen_d;
         err_q      <= err_d;
      end
   end

   assign grant = grant_q;
   assign err   = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of round-robin order, beat framing and sticky errors.
module tb_axi_wr_arbiter;

   localparam int N = 3;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [N*45-1:0] s_awpayload;
   logic [N-1:0]    s_awvalid;
   logic [N-1:0]    s_awready;
   logic [N*41-1:0] s_wpayload;
   logic [N-1:0]    s_wvalid;
   logic [N-1:0]    s_wready;
   logic [3:0]      s_bid;
   logic [1:0]      s_bresp;
   logic [N-1:0]    s_bvalid;
   logic [N-1:0]    s_bready;
   logic [44:0]     m_awpayload;
   logic            m_awvalid;
   logic            m_awready;
   logic [40:0]     m_wpayload;
   logic            m_wvalid;
   logic            m_wready;
   logic [3:0]      m_bid;
   logic [1:0]      m_bresp;
   logic            m_bvalid;
   logic            m_bready;
   logic [N-1:0]    grant;
   logic [2:0]      err;

   axi_wr_arbiter #(.NUM_MST(N)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_awpayload(s_awpayload), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wpayload(s_wpayload), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m_awpayload(m_awpayload), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wpayload(m_wpayload), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .grant(grant), .err(err)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]  awid;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  wid;
      logic [15:0] wl_mask;
      logic [3:0]  bid;
   } txn_t;

   txn_t       pend [N];
   bit         pend_v [N];
   int         model_ptr;
   logic [2:0] exp_err;
   int         n_checks;
   int         n_errors;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int m);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) if (i == m) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [44:0] aw_of(input txn_t t);
      return {t.awid, t.addr, t.len, t.size, t.burst};
   endfunction

   function automatic txn_t mk(input logic [3:0] awid, input logic [31:0] addr, input logic [3:0] len,
                               input logic [3:0] wid, input logic [15:0] wl_mask, input logic [3:0] bid);
      txn_t t;
      t.awid = awid; t.addr = addr; t.len = len; t.size = 3'd2; t.burst = 2'd1;
      t.wid = wid; t.wl_mask = wl_mask; t.bid = bid;
      return t;
   endfunction

   function automatic txn_t clean(input logic [3:0] awid, input logic [3:0] len);
      return mk(awid, $urandom, len, awid, 16'(1) << len, awid);
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.awid    = 4'($urandom);
      t.addr    = $urandom;
      t.len     = 4'($urandom_range(0, 5));
      t.size    = 3'($urandom);
      t.burst   = 2'($urandom);
      t.wid     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : t.awid;
      t.wl_mask = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(1) << t.len;
      t.bid     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : t.awid;
      return t;
   endfunction

   // Next owner: first pending master at or after the pointer, wrapping around.
   function automatic int pick();
      for (int i = 0; i < N; i++) begin
         int m;
         m = (model_ptr + i) % N;
         if (pend_v[m]) return m;
      end
      return -1;
   endfunction

   task automatic post(input int m, input txn_t t);
      pend[m] = t;
      pend_v[m] = 1'b1;
      s_awpayload[45*m +: 45] = aw_of(t);
      s_awvalid = s_awvalid | oh(m);
   endtask

   task automatic rand_w();
      s_wvalid = N'($urandom);
      for (int i = 0; i < N; i++) s_wpayload[41*i +: 41] = 41'({$urandom, $urandom});
   endtask

   task automatic idle_cycle();
      m_awready = 1'($urandom); m_wready = 1'($urandom); m_bvalid = 1'($urandom);
      m_bid = 4'($urandom); m_bresp = 2'($urandom); s_bready = N'($urandom);
      rand_w();
      #1;
      check("idle_grant", 64'(grant), 64'(0));
      check("idle_out", 64'({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}), 64'(0));
      check("err", 64'(err), 64'(exp_err));
      @(negedge aclk);
   endtask

   task automatic clear_model();
      s_awvalid = '0; s_wvalid = '0;
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      model_ptr = 0;
      exp_err = 3'b000;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      clear_model();
      @(negedge aclk);
      idle_cycle();
      aresetn = 1'b1;
   endtask

   task automatic serve_one(input int bhold, input int abort_beat);
      int           w, cyc, beat, drop;
      bit           hs;
      txn_t         t;
      logic [N-1:0] g;
      logic [31:0]  wd;
      logic [3:0]   ws;
      logic         mwl, regen;
      idle_cycle();
      w = pick();
      if (w < 0) return;
      t = pend[w];
      g = oh(w);
      drop = int'($urandom_range(0, 1));
      cyc = 0; hs = 1'b0;
      while (!hs) begin
         if (drop > 0) begin
            s_awvalid = s_awvalid & ~g; m_awready = 1'b1; drop--;
         end else begin
            s_awvalid = s_awvalid | g;
            m_awready = (cyc >= 3) || ($urandom_range(0, 2) != 0);
         end
         m_wready = 1'($urandom); m_bvalid = 1'($urandom); s_bready = N'($urandom);
         rand_w();
         #1;
         check("addr_grant", 64'(grant), 64'(g));
         check("m_awvalid", 64'(m_awvalid), 64'(|(s_awvalid & g)));
         if (|(s_awvalid & g)) check("m_awpayload", 64'(m_awpayload), 64'(aw_of(t)));
         check("s_awready", 64'(s_awready), 64'(m_awready ? g : '0));
         check("addr_quiet", 64'({s_wready, s_bvalid, m_wvalid, m_bready}), 64'(0));
         hs = (|(s_awvalid & g)) && m_awready;
         cyc++;
         @(negedge aclk);
      end
      s_awvalid = s_awvalid & ~g;
      pend_v[w] = 1'b0;

      beat = 0; cyc = 0;
      while (beat <= int'(t.len)) begin
         if (beat == abort_beat) begin
            aresetn = 1'b0;
            @(negedge aclk);
            aresetn = 1'b1;
            clear_model();
            idle_cycle();
            return;
         end
         rand_w();
         wd = $urandom; ws = 4'($urandom); mwl = t.wl_mask[beat[3:0]];
         s_wpayload[41*w +: 41] = {t.wid, wd, ws, mwl};
         if ((cyc >= 3) || ($urandom_range(0, 3) != 0)) s_wvalid = s_wvalid | g;
         else s_wvalid = s_wvalid & ~g;
         m_wready  = (cyc >= 3) || ($urandom_range(0, 3) != 0);
         m_awready = 1'($urandom); m_bvalid = 1'($urandom); s_bready = N'($urandom);
         #1;
         regen = (beat == int'(t.len));
         check("m_wvalid", 64'(m_wvalid), 64'(|(s_wvalid & g)));
         if (|(s_wvalid & g)) check("m_wpayload", 64'(m_wpayload), 64'({t.awid, wd, ws, regen}));
         check("s_wready", 64'(s_wready), 64'(m_wready ? g : '0));
         check("data_quiet", 64'({s_awready, s_bvalid, m_awvalid, m_bready}), 64'(0));
         if ((|(s_wvalid & g)) && m_wready) begin
            if (mwl != regen) exp_err[0] = 1'b1;
            if (t.wid != t.awid) exp_err[1] = 1'b1;
            beat++;
            cyc = 0;
         end else begin
            cyc++;
         end
         @(negedge aclk);
      end

      cyc = 0; hs = 1'b0;
      while (!hs) begin
         m_bid = t.bid; m_bresp = 2'($urandom);
         s_bready = N'($urandom);
         if (cyc < bhold) begin
            m_bvalid = 1'b1;
            s_bready = s_bready & ~g;
         end else begin
            m_bvalid = (bhold > 0) || (cyc >= 3) || ($urandom_range(0, 2) != 0);
            if ((bhold > 0) || (cyc >= 3) || ($urandom_range(0, 2) != 0)) s_bready = s_bready | g;
         end
         m_awready = 1'($urandom); m_wready = 1'($urandom);
         rand_w();
         #1;
         check("resp_grant", 64'(grant), 64'(g));
         check("s_bvalid", 64'(s_bvalid), 64'(m_bvalid ? g : '0));
         check("m_bready", 64'(m_bready), 64'(|(s_bready & g)));
         if (m_bvalid) check("s_bid_bresp", 64'({s_bid, s_bresp}), 64'({m_bid, m_bresp}));
         check("resp_quiet", 64'({s_awready, s_wready, m_awvalid, m_wvalid}), 64'(0));
         hs = m_bvalid && (|(s_bready & g));
         if (hs) begin
            if (t.bid != t.awid) exp_err[2] = 1'b1;
            model_ptr = (w + 1) % N;
         end
         cyc++;
         @(negedge aclk);
      end
      m_bvalid = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      aresetn = 1'b0;
      s_awpayload = '0; s_awvalid = '0; s_wpayload = '0; s_wvalid = '0; s_bready = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
      clear_model();
      do_reset();

      // Single master, 4-beat well-formed burst.
      post(0, mk(4'd3, 32'h100, 4'd3, 4'd3, 16'h0008, 4'd3));
      serve_one(0, -1);

      // Simultaneous requests after reset alternate fairly.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         post(0, clean(4'd1, 4'd1));
         post(1, clean(4'd2, 4'd2));
         serve_one(0, -1);
         serve_one(0, -1);
      end

      // Early wlast still yields awlen+1 beats; err[0] stays set afterwards.
      post(1, mk(4'd6, 32'h200, 4'd1, 4'd6, 16'h0001, 4'd6));
      serve_one(0, -1);
      post(2, clean(4'd4, 4'd2));
      serve_one(0, -1);

      // Bad wid, then bad bid.
      post(0, mk(4'd2, 32'h300, 4'd2, 4'd5, 16'h0004, 4'd2));
      serve_one(0, -1);
      post(0, mk(4'd2, 32'h340, 4'd0, 4'd2, 16'h0001, 4'd7));
      serve_one(0, -1);

      // Response back-pressure for three cycles.
      post(0, clean(4'd9, 4'd1));
      serve_one(3, -1);

      for (int k = 0; k < 40; k++) begin
         for (int m = 0; m < N; m++)
            if (!pend_v[m] && ($urandom_range(0, 1) != 0)) post(m, rand_txn());
         if (pick() < 0) post(int'($urandom_range(0, N - 1)), rand_txn());
         serve_one(0, -1);
      end
      while (pick() >= 0) serve_one(0, -1);

      // Reset during beat 2 of an 8-beat burst, after the pointer has moved off zero.
      post(0, clean(4'd1, 4'd0));
      serve_one(0, -1);
      post(1, clean(4'd5, 4'd7));
      serve_one(0, 2);
      post(0, clean(4'd3, 4'd1));
      post(1, clean(4'd8, 4'd0));
      serve_one(0, -1);
      serve_one(0, -1);
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
